// File: rtl/sort_mem_arbiter_if.sv
// Bundle of host, sort-engine and memory signals around the sort memory arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface sort_mem_arbiter_if;
   logic       h_req;
   logic       h_we;
   logic [3:0] h_addr;
   logic [7:0] h_wdata;
   logic       h_ack;
   logic       e_req;
   logic       e_we;
   logic [3:0] e_addr;
   logic [7:0] e_wdata;
   logic       e_ack;
   logic       e_lock;
   logic [3:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       mem_we;
   logic [7:0] mem_rdata;
   logic [7:0] rdata;
   logic       owner;
   logic       busy;

   modport slave (
      input  h_req, h_we, h_addr, h_wdata, e_req, e_we, e_addr, e_wdata, e_lock, mem_rdata,
      output h_ack, e_ack, mem_addr, mem_wdata, mem_we, rdata, owner, busy
   );

   modport master (
      output h_req, h_we, h_addr, h_wdata, e_req, e_we, e_addr, e_wdata, e_lock, mem_rdata,
      input  h_ack, e_ack, mem_addr, mem_wdata, mem_we, rdata, owner, busy
   );
endinterface

// File: rtl/sort_mem_arbiter.sv
// Two-port (host / sort engine) arbiter onto a single synchronous-read memory, 3 cycles per access.
// Define SORT_ARB_RR_EN for round-robin ties; otherwise the engine always wins a tie.
module sort_mem_arbiter (
   input  logic                  clk,
   input  logic                  rst,
   sort_mem_arbiter_if.slave     bus
);

   typedef enum logic [1:0] {IDLE, CMD, RESP} state_t;

   state_t     state;
   logic       cur_we;
   logic [7:0] rdata_q;
   logic       h_elig;
   logic       e_elig;
   logic       grant_e;

   // Host is locked out only at the sampling edge; an access already granted always completes.
   assign h_elig = bus.h_req && !bus.e_lock;
   assign e_elig = bus.e_req;

`ifdef SORT_ARB_RR_EN
   assign grant_e = e_elig && (!h_elig || !bus.owner);
`else
   assign grant_e = e_elig;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         cur_we        <= 1'b0;
         rdata_q       <= 8'h00;
         bus.h_ack     <= 1'b0;
         bus.e_ack     <= 1'b0;
         bus.mem_addr  <= 4'h0;
         bus.mem_wdata <= 8'h00;
         bus.mem_we    <= 1'b0;
         bus.owner     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (e_elig || h_elig) begin
                  bus.owner     <= grant_e;
                  bus.mem_addr  <= grant_e ? bus.e_addr  : bus.h_addr;
                  bus.mem_wdata <= grant_e ? bus.e_wdata : bus.h_wdata;
                  bus.mem_we    <= grant_e ? bus.e_we    : bus.h_we;
                  cur_we        <= grant_e ? bus.e_we    : bus.h_we;
                  state         <= CMD;
               end else begin
                  bus.mem_we <= 1'b0;
               end
            end
            CMD: begin
               bus.mem_we <= 1'b0;
               bus.e_ack  <= bus.owner;
               bus.h_ack  <= !bus.owner;
               state      <= RESP;
            end
            RESP: begin
               bus.h_ack  <= 1'b0;
               bus.e_ack  <= 1'b0;
               bus.mem_we <= 1'b0;
               if (!cur_we) rdata_q <= bus.mem_rdata;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Read data is valid from memory during RESP, so it is forwarded in the ack cycle.
   assign bus.rdata = (state == RESP && !cur_we) ? bus.mem_rdata : rdata_q;
   assign bus.busy  = (state != IDLE);

endmodule

// File: doc/sort_mem_arbiter.md
SORT_MEM_ARBITER -- requirements
Module: sort_mem_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state on rising edge.
REQ-002 SHALL have: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have host port: h_req in 1, h_we in 1, h_addr in 4, h_wdata in 8, h_ack out 1.
REQ-004 SHALL have engine port: e_req in 1, e_we in 1, e_addr in 4, e_wdata in 8, e_ack out 1, e_lock in 1 (asserted by the sort engine for the whole sort run).
REQ-005 SHALL have memory port: mem_addr out 4, mem_wdata out 8, mem_we out 1, mem_rdata in 8 (synchronous read, data valid the cycle after the address is presented).
REQ-006 SHALL have: rdata out 8 (read data for the acked requester), owner out 1 (0 host, 1 engine, last grant), busy out 1 (state not IDLE).

Function
REQ-007 SHALL implement FSM states IDLE, CMD and RESP.
REQ-008 In IDLE with an eligible request, SHALL register the winner's addr/wdata/we onto mem_addr/mem_wdata/mem_we, set owner, and go to CMD.
REQ-009 In IDLE with no eligible request, SHALL stay in IDLE with mem_we=0.
REQ-010 In CMD, SHALL drive mem_we for exactly this one cycle on writes (never on reads), hold mem_addr, and go to RESP.
REQ-011 In RESP, SHALL pulse the winner's ack for one cycle, load rdata from mem_rdata (reads only; writes leave rdata unchanged), clear mem_we, and return to IDLE.
REQ-012 Latency: req sampled high in IDLE at edge N gives ack high during cycle N+2, so each access takes 3 cycles.
REQ-013 A requester SHALL hold req, we, addr and wdata stable until its ack; req still high in the IDLE cycle after ack is a new request.
REQ-014 Host is eligible only when e_lock=0 at the IDLE sampling edge; the engine is always eligible.
REQ-015 e_lock rising while a host access is in CMD/RESP SHALL NOT abort it; the host access completes and its ack is issued.
REQ-016 With e_lock=1 and e_req held, engine accesses SHALL run back-to-back, one per 3 cycles, with no host interleave.
REQ-017 Arbitration when both are eligible in the same cycle follows REQ-023/REQ-024.
REQ-018 h_ack and e_ack SHALL never be high in the same cycle; at most one access is outstanding.
REQ-019 Address wrap: none; 4-bit addresses pass through unmodified (16 locations).

Reset
REQ-020 rst high SHALL force IDLE immediately, and set h_ack=e_ack=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0, owner=0 and busy=0.
REQ-021 Reset during CMD/RESP SHALL drop the in-flight access with no ack and no write after release.
REQ-022 After release, the first access SHALL start on the first rising edge with rst low.

Configuration
REQ-023 With SORT_ARB_RR_EN defined, a tie SHALL be granted round-robin to the port opposite the previous owner; after reset the engine wins the first tie.
REQ-024 Without SORT_ARB_RR_EN, a tie SHALL always be granted to the engine (fixed priority).

Verification
REQ-025 Host write addr 3 data 0xA5 with lock=0 -> mem_we high in exactly one cycle with mem_addr=3 and mem_wdata=0xA5, then h_ack 2 cycles after req sampled.
REQ-026 Host read addr 3 after REQ-025 write (memory model) -> h_ack pulse with rdata=0xA5 in the same cycle.
REQ-027 e_lock=1 with h_req held for 20 cycles -> no h_ack and no host mem access; e_lock drops -> h_ack within 3 cycles.
REQ-028 h_req and e_req high in the same cycle, both held for 4 accesses -> RR: e,h,e,h acks; non-RR: e,e,e,e acks.
REQ-029 Host read issued, e_lock raised in the CMD cycle -> host access completes with h_ack, then the engine is served.
REQ-030 rst pulsed during CMD of an engine write -> mem_we=0 immediately, no e_ack, and all outputs at reset values.
